seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Recovers the hex digits shown on the board's time-multiplexed, common-anode 7-segment display by sampling the active-low anode and segment lines. This is the inverse of the hex-to-segment encoding. It sits beside the display driver as an on-chip self-check monitor and as a readback path for the top-level status logic. Each scanned digit slot is accepted once its pattern has been stable for a configurable number of cycles.

## Interface
- `NUM_DIGITS`, 4: number of anode slots scanned.
- `STABLE_CYCLES`, 16: consecutive identical samples required before a slot is captured; legal range 2..255.
- `clk` input 1: system clock, single clock domain.
- `rst` input 1: synchronous, active-high reset.
- `an` input NUM_DIGITS: anode enables, active-low; bit i selects digit slot i.
- `seg` input 7: segment lines `{g,f,e,d,c,b,a}`, active-low.
- `digits` output 4*NUM_DIGITS: decoded nibbles; slot i occupies bits `[4i+3:4i]`.
- `digit_known` output NUM_DIGITS: bit i is 1 when the last capture on slot i matched a legal pattern.
- `frame_done` output 1: one-cycle pulse when every slot has been captured since the previous pulse.
- `bad_pattern` output 1: one-cycle pulse on a capture whose pattern is not in the table.

## Operation
- `an` and `seg` are registered once on input to form sample `s`. The previous sample `s_d` is also kept.
- A slot is valid when exactly one bit of `an` is low. Zero or more than one low bit is treated as no slot.
- FSM states:
  - **IDLE**: no valid slot. Goes to SETTLE when the sample shows a valid slot; the counter is loaded with 0.
  - **SETTLE**: counts consecutive cycles with `s == s_d`.
    - When `s != s_d` with a valid slot, the counter reloads to 0 and the FSM stays in SETTLE.
    - When the slot becomes invalid, the FSM goes to IDLE.
    - When the counter reaches `STABLE_CYCLES-1`, a capture happens and the FSM goes to HELD.
  - **HELD**: no recapture while `s == s_d`. Any change returns to SETTLE (valid slot, counter 0) or to IDLE (invalid slot).
- Capture on slot i:
  - A legal pattern writes the nibble into `digits[4i+3:4i]`, sets `digit_known[i]=1` and sets `seen[i]`.
  - An illegal pattern leaves the nibble unchanged, clears `digit_known[i]`, pulses `bad_pattern` and still sets `seen[i]`.
- Legal pattern table (segment hex → nibble): 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9, 0x3F→A (dash), 0x03→B, 0x46→C, 0x21→D, 0x06→E, 0x7F→F (blank). All other patterns are illegal.
- Frame completion:
  - When the capture that completes `seen` all-ones occurs, `frame_done` pulses in the following cycle and `seen` clears.
  - A capture on a slot already seen in the current frame overwrites its nibble and does not advance the frame.

## Timing
- Reset values:
  - `digits` all 0xF (blank).
  - `digit_known` all 0.
  - `frame_done`, `bad_pattern`: 0.
  - FSM in IDLE, counter 0, `seen` all 0.
- Latency: pins stable from edge k → `digits` updated at edge k+`STABLE_CYCLES`+2.
- `frame_done` and `bad_pattern` are registered. `bad_pattern` asserts in the same cycle as the capture's `digits`/`digit_known` update. `frame_done` asserts one cycle later.
- A capture and a completing frame in back-to-back cycles are both reported; no events are dropped.
- `rst` mid-SETTLE aborts the capture. Outputs return to reset values at the next edge, and the input registers are also cleared to all-ones (no slot).
- The counter saturates and never wraps in HELD.

## Configuration
- `SEG7_SCAN_DECODER_DP_EN` defined:
  - Adds input `dp` (1 bit, active-low) and output `dp_out` (NUM_DIGITS, active-high, reset 0).
  - `dp` is part of the sample compared for stability.
  - On each capture on slot i, `dp_out[i]` takes the captured decimal point.
- Undefined: no `dp` or `dp_out` ports; the decimal point plays no part in stability or capture.

## Structure
- Shared package `seg7_pkg` holds:
  - Pattern constants `SEG_0`..`SEG_F`, shared with the encoder.
  - The FSM state typedef (IDLE/SETTLE/HELD).
  - The default digit count.
- One sub-module, `seg7_to_hex`: combinational reverse lookup. Input is the 7-bit pattern; outputs are the nibble and a `known` flag.

## Test plan
- Reset, then idle with `an`=4'b1111 → `digits`=16'hFFFF, `digit_known`=0, no pulses.
- Hold `an`=4'b1110, `seg`=0x30 for 20 cycles → `digits[3:0]`=3 and `digit_known[0]`=1 exactly `STABLE_CYCLES`+2 edges after the change; a single capture.
- Scan slots 0..3 with 0x40, 0x79, 0x24, 0x46, each held 20 cycles → `digits`=16'hC210; one `frame_done` pulse after slot 3.
- `seg` glitches every 8 cycles (below 16) on slot 1 → no capture; `digits` unchanged.
- Slot 2 showing 0x55 → one `bad_pattern` pulse, `digit_known[2]`=0, nibble kept; `an`=4'b1100 → treated as no slot, no capture.
- Assert `rst` at counter 10 in SETTLE → all outputs at reset values next cycle; no capture follows.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions used by the display encoder and by the scan decoder.
// Patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int unsigned SEG7_NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h3F;  // dash
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h7F;  // blank

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HELD
  } seg7_state_t;

  // Forward encoding, used by the display driver side.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    unique case (nib)
      4'h0: pat = SEG_0;
      4'h1: pat = SEG_1;
      4'h2: pat = SEG_2;
      4'h3: pat = SEG_3;
      4'h4: pat = SEG_4;
      4'h5: pat = SEG_5;
      4'h6: pat = SEG_6;
      4'h7: pat = SEG_7;
      4'h8: pat = SEG_8;
      4'h9: pat = SEG_9;
      4'hA: pat = SEG_A;
      4'hB: pat = SEG_B;
      4'hC: pat = SEG_C;
      4'hD: pat = SEG_D;
      4'hE: pat = SEG_E;
      default: pat = SEG_F;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Pin-side and result-side signals of the scan decoder.
// Optional decimal-point capture: SEG7_SCAN_DECODER_DP_EN.
interface seg7_scan_decoder_if
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = SEG7_NUM_DIGITS
);
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_known;
  logic                    frame_done;
  logic                    bad_pattern;
`ifdef SEG7_SCAN_DECODER_DP_EN
  logic                    dp;
  logic [NUM_DIGITS-1:0]   dp_out;

  modport master (
    output an, seg, dp,
    input  digits, digit_known, frame_done, bad_pattern, dp_out
  );
  modport slave (
    input  an, seg, dp,
    output digits, digit_known, frame_done, bad_pattern, dp_out
  );
`else
  modport master (
    output an, seg,
    input  digits, digit_known, frame_done, bad_pattern
  );
  modport slave (
    input  an, seg,
    output digits, digit_known, frame_done, bad_pattern
  );
`endif
endinterface

// File: rtl/seg7_to_hex.sv
// Reverse lookup of an active-low segment pattern to its hex nibble.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] nibble_o,
  output logic       known_o
);

  // Table lookup; unknown patterns flag known_o low.
  always_comb begin
    nibble_o = 4'hF;
    known_o  = 1'b1;
    unique case (pattern_i)
      SEG_0: nibble_o = 4'h0;
      SEG_1: nibble_o = 4'h1;
      SEG_2: nibble_o = 4'h2;
      SEG_3: nibble_o = 4'h3;
      SEG_4: nibble_o = 4'h4;
      SEG_5: nibble_o = 4'h5;
      SEG_6: nibble_o = 4'h6;
      SEG_7: nibble_o = 4'h7;
      SEG_8: nibble_o = 4'h8;
      SEG_9: nibble_o = 4'h9;
      SEG_A: nibble_o = 4'hA;
      SEG_B: nibble_o = 4'hB;
      SEG_C: nibble_o = 4'hC;
      SEG_D: nibble_o = 4'hD;
      SEG_E: nibble_o = 4'hE;
      SEG_F: nibble_o = 4'hF;
      default: known_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a multiplexed common-anode 7-segment display.
// A slot is captured after its sample has been stable for STABLE_CYCLES cycles.
// Optional decimal-point capture: SEG7_SCAN_DECODER_DP_EN.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = SEG7_NUM_DIGITS,
  parameter int unsigned STABLE_CYCLES = 16
)(
  input logic                clk,
  input logic                rst,
  seg7_scan_decoder_if.slave bus
);

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  logic [NUM_DIGITS-1:0] an_q, an_p_q;
  logic [6:0]            seg_q, seg_p_q;
`ifdef SEG7_SCAN_DECODER_DP_EN
  logic                  dp_q, dp_p_q;
  logic                  cap_dp_q;
  logic [NUM_DIGITS-1:0] dp_out_q;
`endif

  seg7_state_t           state_q;
  logic [7:0]            cnt_q;
  logic                  cap_q;
  logic [NUM_DIGITS-1:0] cap_slot_q;
  logic [6:0]            cap_pat_q;

  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   known_q;
  logic [NUM_DIGITS-1:0]   seen_q;
  logic                    bad_q;
  logic                    frame_q;

  logic                  slot_valid;
  logic                  sample_eq;
  logic [NUM_DIGITS-1:0] cap_mask;
  logic [3:0]            dec_nib;
  logic                  dec_known;

  // Sample classification: exactly one low anode is a slot; stability vs previous sample.
  always_comb begin
    slot_valid = $onehot(~an_q);
    sample_eq  = (an_q == an_p_q) && (seg_q == seg_p_q);
`ifdef SEG7_SCAN_DECODER_DP_EN
    sample_eq  = sample_eq && (dp_q == dp_p_q);
`endif
    cap_mask   = cap_q ? cap_slot_q : '0;
  end

  // Input sample and previous-sample registers; reset to "no slot".
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q    <= '1;
      an_p_q  <= '1;
      seg_q   <= '1;
      seg_p_q <= '1;
`ifdef SEG7_SCAN_DECODER_DP_EN
      dp_q    <= 1'b1;
      dp_p_q  <= 1'b1;
`endif
    end else begin
      an_q    <= bus.an;
      an_p_q  <= an_q;
      seg_q   <= bus.seg;
      seg_p_q <= seg_q;
`ifdef SEG7_SCAN_DECODER_DP_EN
      dp_q    <= bus.dp;
      dp_p_q  <= dp_q;
`endif
    end
  end

  // Stability FSM; a capture latches slot and pattern and is applied one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cap_q      <= 1'b0;
      cap_slot_q <= '0;
      cap_pat_q  <= '1;
`ifdef SEG7_SCAN_DECODER_DP_EN
      cap_dp_q   <= 1'b1;
`endif
    end else begin
      cap_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (slot_valid) state_q <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (!slot_valid) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (!sample_eq) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            // Counter stays at CNT_LAST while HELD, so it saturates rather than wraps.
            state_q    <= ST_HELD;
            cap_q      <= 1'b1;
            cap_slot_q <= ~an_q;
            cap_pat_q  <= seg_q;
`ifdef SEG7_SCAN_DECODER_DP_EN
            cap_dp_q   <= dp_q;
`endif
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_HELD: begin
          if (!sample_eq) begin
            state_q <= slot_valid ? ST_SETTLE : ST_IDLE;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  seg7_to_hex u_dec (
    .pattern_i (cap_pat_q),
    .nibble_o  (dec_nib),
    .known_o   (dec_known)
  );

  // Apply a pending capture to the digit registers and raise bad_pattern alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q <= '1;
      known_q  <= '0;
      bad_q    <= 1'b0;
`ifdef SEG7_SCAN_DECODER_DP_EN
      dp_out_q <= '0;
`endif
    end else begin
      bad_q <= cap_q && !dec_known;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (cap_mask[i]) begin
          known_q[i] <= dec_known;
          if (dec_known) digits_q[4*i +: 4] <= dec_nib;
`ifdef SEG7_SCAN_DECODER_DP_EN
          dp_out_q[i] <= ~cap_dp_q;
`endif
        end
      end
    end
  end

  // Frame tracking: a full seen mask pulses frame_done next cycle; a capture landing
  // in that same cycle starts the new frame so no event is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_q  <= '0;
      frame_q <= 1'b0;
    end else if (seen_q == '1) begin
      seen_q  <= cap_mask;
      frame_q <= 1'b1;
    end else begin
      seen_q  <= seen_q | cap_mask;
      frame_q <= 1'b0;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_known = known_q;
  assign bus.bad_pattern = bad_q;
  assign bus.frame_done  = frame_q;
`ifdef SEG7_SCAN_DECODER_DP_EN
  assign bus.dp_out      = dp_out_q;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scenarios plus random scans,
// every cycle compared against a pin-level behavioural model.
module tb_seg7_scan_decoder;

  localparam int unsigned ND = 4;
  localparam int unsigned S  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;

  // Model state
  logic [6:0]  table_q [16];
  logic [3:0]  m_prev_an;
  logic [6:0]  m_prev_seg;
  int          m_run;
  bit          p1_v, p2_v;
  int          p1_slot, p2_slot;
  logic [6:0]  p1_seg, p2_seg;
  logic [15:0] m_digits;
  logic [3:0]  m_known;
  logic [3:0]  m_seen;
  bit          m_frame_pend;
  logic        e_bad, e_frame;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_prev_an = '1; m_prev_seg = '1; m_run = 1;
    p1_v = 0; p2_v = 0;
    m_digits = 16'hFFFF; m_known = '0; m_seen = '0;
    m_frame_pend = 0; e_bad = 0; e_frame = 0;
  endtask

  task automatic model_apply(input int slot, input logic [6:0] sg);
    int idx = -1;
    for (int n = 0; n < 16; n++) if (table_q[n] == sg) idx = n;
    if (idx >= 0) begin
      m_digits[4*slot +: 4] = 4'(idx);
      m_known[slot] = 1'b1;
    end else begin
      m_known[slot] = 1'b0;
      e_bad = 1'b1;
    end
    m_seen[slot] = 1'b1;
    if (m_seen == 4'hF) begin
      m_frame_pend = 1;
      m_seen = '0;
    end
  endtask

  // One clock edge of the model: a sample that completes S+1 identical samples on a
  // valid slot becomes visible on the outputs two edges later.
  task automatic model_edge(input logic r, input logic [3:0] an, input logic [6:0] sg);
    int zeros, slot;
    if (r) begin
      model_reset();
      return;
    end
    e_bad = 0;
    e_frame = m_frame_pend;
    m_frame_pend = 0;
    if (p2_v) model_apply(p2_slot, p2_seg);
    p2_v = p1_v; p2_slot = p1_slot; p2_seg = p1_seg;
    p1_v = 0;
    if (an == m_prev_an && sg == m_prev_seg) begin
      if (m_run < 1000) m_run++;
    end else m_run = 1;
    m_prev_an = an; m_prev_seg = sg;
    zeros = 0; slot = 0;
    for (int b = 0; b < 4; b++) if (!an[b]) begin zeros++; slot = b; end
    if (m_run == S + 1 && zeros == 1) begin
      p1_v = 1; p1_slot = slot; p1_seg = sg;
    end
  endtask

  task automatic step(input logic r, input logic [3:0] an, input logic [6:0] sg);
    rst = r; bus.an = an; bus.seg = sg;
    @(posedge clk); #1;
    model_edge(r, an, sg);
    chk("digits", 32'(bus.digits), 32'(m_digits));
    chk("digit_known", 32'(bus.digit_known), 32'(m_known));
    chk("bad_pattern", 32'(bus.bad_pattern), 32'(e_bad));
    chk("frame_done", 32'(bus.frame_done), 32'(e_frame));
`ifdef SEG7_SCAN_DECODER_DP_EN
    chk("dp_out", 32'(bus.dp_out), 32'(0));
`endif
  endtask

  initial begin
    logic [3:0]  an_r;
    logic [6:0]  seg_r;
    logic [15:0] last_digits;
    int first_known, changes, frames, bads;
    logic [6:0] scan_seg [4];

    table_q = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h03, 7'h46, 7'h21, 7'h06, 7'h7F};
    scan_seg = '{7'h40, 7'h79, 7'h24, 7'h46};
    bus.an = '1; bus.seg = '1;
`ifdef SEG7_SCAN_DECODER_DP_EN
    bus.dp = 1'b1;
`endif
    model_reset();

    // Reset and idle
    for (int n = 0; n < 3; n++) step(1'b1, 4'b1111, 7'h7F);
    for (int n = 0; n < 5; n++) step(1'b0, 4'b1111, 7'h7F);
    chk("idle_digits", 32'(bus.digits), 32'h0000_FFFF);

    // Single capture on slot 0 and its latency in edges
    first_known = 0; changes = 0; last_digits = bus.digits;
    for (int n = 1; n <= 25; n++) begin
      step(1'b0, 4'b1110, 7'h30);
      if (first_known == 0 && bus.digit_known[0]) first_known = n;
      if (bus.digits !== last_digits) changes++;
      last_digits = bus.digits;
    end
    chk("latency_step", 32'(first_known), 32'(S + 3));
    chk("single_capture", 32'(changes), 32'd1);
    chk("slot0_value", 32'(bus.digits[3:0]), 32'h3);

    // Full scan: one frame
    frames = 0;
    for (int d = 0; d < 4; d++) begin
      an_r = 4'b1111; an_r[d] = 1'b0;
      for (int n = 0; n < 20; n++) begin
        step(1'b0, an_r, scan_seg[d]);
        if (bus.frame_done) frames++;
      end
    end
    chk("scan_digits", 32'(bus.digits), 32'h0000_C210);
    chk("scan_frames", 32'(frames), 32'd1);

    // Glitching pattern on slot 1 never settles
    for (int n = 0; n < 48; n++) step(1'b0, 4'b1101, ((n / 8) % 2 == 0) ? 7'h24 : 7'h79);
    chk("glitch_digits", 32'(bus.digits), 32'h0000_C210);

    // Illegal pattern on slot 2, then a two-slot anode pattern
    bads = 0;
    for (int n = 0; n < 20; n++) begin
      step(1'b0, 4'b1011, 7'h55);
      if (bus.bad_pattern) bads++;
    end
    chk("bad_count", 32'(bads), 32'd1);
    chk("bad_known2", 32'(bus.digit_known[2]), 32'd0);
    chk("bad_nibble2", 32'(bus.digits[11:8]), 32'h2);
    for (int n = 0; n < 25; n++) begin
      step(1'b0, 4'b1100, 7'h40);
      if (bus.bad_pattern) bads++;
    end
    chk("twoslot_digits", 32'(bus.digits), 32'h0000_C210);
    chk("twoslot_bad", 32'(bads), 32'd1);

    // Reset while counter is at 10 in SETTLE
    for (int n = 0; n < 12; n++) step(1'b0, 4'b0111, 7'h19);
    step(1'b1, 4'b0111, 7'h19);
    chk("rst_digits", 32'(bus.digits), 32'h0000_FFFF);
    chk("rst_known", 32'(bus.digit_known), 32'd0);
    for (int n = 0; n < 25; n++) step(1'b0, 4'b1111, 7'h7F);
    chk("post_rst_known", 32'(bus.digit_known), 32'd0);

    // Random scans against the model
    for (int seg_i = 0; seg_i < 60; seg_i++) begin
      if ($urandom_range(0, 9) < 7) begin
        an_r = 4'b1111; an_r[$urandom_range(0, 3)] = 1'b0;
      end else an_r = 4'($urandom);
      if ($urandom_range(0, 9) < 7) seg_r = table_q[$urandom_range(0, 15)];
      else seg_r = 7'($urandom);
      for (int n = 0, len = $urandom_range(1, 25); n < len; n++) step(1'b0, an_r, seg_r);
    end
    for (int n = 0; n < 4; n++) step(1'b0, 4'b1111, 7'h7F);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
